// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states and the
// write-back predicate.
package alu_pkg;

    localparam logic [2:0] OP_SUMA        = 3'd0;
    localparam logic [2:0] OP_COMPLEMENTO = 3'd1;
    localparam logic [2:0] OP_SHIFT_L     = 3'd2;
    localparam logic [2:0] OP_SHIFT_R     = 3'd3;
    localparam logic [2:0] OP_COMPC       = 3'd4;
    localparam logic [2:0] OP_COMPN       = 3'd5;
    localparam logic [2:0] OP_LOAD        = 3'd6;
    localparam logic [2:0] OP_SAVE        = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_EXEC  = 3'd3,
        S_WB    = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    // Comparisons only report status; every other unit updates the register.
    function automatic logic writes_back(input logic [2:0] opcode);
        return (opcode != OP_COMPC) && (opcode != OP_COMPN);
    endfunction

endpackage

// File: rtl/alu_watchdog.sv
// Execution watchdog: loads TIMEOUT_CYC on clear, counts down while run is
// high and flags the last allowed cycle so the sequencer can give up.
module alu_watchdog #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [7:0] LOAD_VAL = 8'(TIMEOUT_CYC);

    logic [7:0] count;

    // Down-counter; stops at zero so it never wraps if run lingers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= LOAD_VAL;
        end else if (run && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    // count == 1 marks the TIMEOUT_CYC-th running cycle.
    assign expired = run && (count == 8'd1);

endmodule

// File: rtl/alu_sequencer.sv
// One-instruction-at-a-time ALU sequencer: accept command, read operand pair,
// enable the selected unit, wait for its done, merge the nibble result back
// into the register and hand out a response.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int RF_AW       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opcode,
    input  logic [RF_AW-1:0] cmd_reg,
    input  logic             cmd_pos,
    output logic             rf_rd_en,
    output logic [RF_AW-1:0] rf_rd_addr,
    input  logic [7:0]       rf_rd_data,
    output logic [7:0]       op_en,
    output logic [7:0]       op_data,
    input  logic [7:0]       unit_done,
    input  logic [3:0]       unit_result,
    output logic             rf_wr_en,
    output logic [RF_AW-1:0] rf_wr_addr,
    output logic [7:0]       rf_wr_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [3:0]       resp_result,
    output logic             resp_err,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic [2:0]       opc_q;
    logic [RF_AW-1:0] reg_q;
    logic             pos_q;
    logic [7:0]       op_data_q;
    logic [3:0]       result_q;
    logic             err_q;
    logic             unit_hit;
    logic             wd_clear;
    logic             wd_run;
    logic             wd_expired;

    // Only the selected unit's done bit matters; the others are ignored.
    assign unit_hit = unit_done[opc_q];
    assign wd_clear = (state == S_LATCH);
    assign wd_run   = (state == S_EXEC);

    alu_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .run     (wd_run),
        .expired (wd_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a done in the timeout cycle still wins over the timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (cmd_valid && cmd_ready) state_next = S_FETCH;
            S_FETCH: state_next = S_LATCH;
            S_LATCH: state_next = S_EXEC;
            S_EXEC: begin
                if (unit_hit) begin
                    state_next = S_WB;
                end else if (wd_expired) begin
                    state_next = S_RESP;
                end
            end
            S_WB:    state_next = S_RESP;
            S_RESP:  if (resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they are glitch-free and
    // line up exactly with the state they belong to; datapath captures here too.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready  <= 1'b0;
            rf_rd_en   <= 1'b0;
            op_en      <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_data <= '0;
            resp_valid <= 1'b0;
            opc_q      <= '0;
            reg_q      <= '0;
            pos_q      <= 1'b0;
            op_data_q  <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            cmd_ready  <= (state_next == S_IDLE);
            rf_rd_en   <= (state_next == S_FETCH);
            op_en      <= (state_next == S_EXEC) ? (8'b1 << opc_q) : 8'h00;
            rf_wr_en   <= (state_next == S_WB) && writes_back(opc_q);
            resp_valid <= (state_next == S_RESP);

            if ((state == S_IDLE) && cmd_valid && cmd_ready) begin
                opc_q <= cmd_opcode;
                reg_q <= cmd_reg;
                pos_q <= cmd_pos;
            end

            if (state == S_LATCH) begin
                op_data_q <= rf_rd_data;
            end

            if (state == S_EXEC) begin
                if (unit_hit) begin
                    result_q   <= unit_result;
                    err_q      <= 1'b0;
                    rf_wr_data <= pos_q ? {op_data_q[7:4], unit_result}
                                        : {unit_result, op_data_q[3:0]};
                end else if (wd_expired) begin
                    result_q <= 4'h0;
                    err_q    <= 1'b1;
                end
            end
        end
    end

    assign rf_rd_addr  = reg_q;
    assign rf_wr_addr  = reg_q;
    assign op_data     = op_data_q;
    assign resp_result = result_q;
    assign resp_err    = err_q;
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: acts as register file and operation units, drives
// table vectors, reset corner cases and random commands, checking against a
// transaction-level expectation of each command.
module tb_alu_sequencer;

    localparam int TO = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_opcode;
    logic [AW-1:0] cmd_reg;
    logic          cmd_pos;
    logic          rf_rd_en;
    logic [AW-1:0] rf_rd_addr;
    logic [7:0]    rf_rd_data;
    logic [7:0]    op_en;
    logic [7:0]    op_data;
    logic [7:0]    unit_done;
    logic [3:0]    unit_result;
    logic          rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [7:0]    rf_wr_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [3:0]    resp_result;
    logic          resp_err;
    logic          busy;

    alu_sequencer #(
        .TIMEOUT_CYC (TO),
        .RF_AW       (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_reg     (cmd_reg),
        .cmd_pos     (cmd_pos),
        .rf_rd_en    (rf_rd_en),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .op_en       (op_en),
        .op_data     (op_data),
        .unit_done   (unit_done),
        .unit_result (unit_result),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // One command with its environment behaviour and expected outcome.
    // d = index of the EXEC cycle in which the unit reports done (-1 = never).
    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] rg;
        logic          pos;
        logic [7:0]    init;
        int            d;
        logic [3:0]    res;
        logic [7:0]    spur;
        int            bp;
        logic [7:0]    exp_en;
        int            exp_en_cyc;
        logic          exp_wr;
        logic [7:0]    exp_wdata;
        logic [3:0]    exp_result;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] rf_mem [8];
    int         env_en;
    bit         env_prev_rd;
    logic [AW-1:0] env_prev_addr;
    vec_t       tbl [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] op, input logic [AW-1:0] rg,
                                 input logic pos, input logic [7:0] init, input int d,
                                 input logic [3:0] res, input logic [7:0] spur, input int bp,
                                 input logic [7:0] exp_en, input int exp_en_cyc,
                                 input logic exp_wr, input logic [7:0] exp_wdata,
                                 input logic [3:0] exp_result, input logic exp_err,
                                 input int exp_lat);
        vec_t v;
        v.op = op; v.rg = rg; v.pos = pos; v.init = init; v.d = d;
        v.res = res; v.spur = spur; v.bp = bp;
        v.exp_en = exp_en; v.exp_en_cyc = exp_en_cyc; v.exp_wr = exp_wr;
        v.exp_wdata = exp_wdata; v.exp_result = exp_result; v.exp_err = exp_err;
        v.exp_lat = exp_lat;
        return v;
    endfunction

    // Transaction-level expectation: what a command should do, from its rules.
    function automatic vec_t model(input logic [2:0] op, input logic [AW-1:0] rg,
                                   input logic pos, input logic [7:0] init, input int d,
                                   input logic [3:0] res, input logic [7:0] spur, input int bp);
        vec_t v;
        bit   done;
        bit   is_cmp;
        done   = (d >= 0) && (d < TO);
        is_cmp = (op == 3'd4) || (op == 3'd5);
        v = mkv(op, rg, pos, init, d, res, spur, bp,
                8'(1 << op),
                done ? d + 1 : TO,
                done && !is_cmp,
                pos ? {init[7:4], res} : {res, init[3:0]},
                done ? res : 4'h0,
                !done,
                done ? 5 + d : 3 + TO);
        return v;
    endfunction

    // Register file and unit behaviour for one cycle (called at negedge).
    task automatic env_step(input vec_t v);
        if (env_prev_rd) rf_rd_data = rf_mem[env_prev_addr];
        else             rf_rd_data = 8'($urandom);
        env_prev_rd   = rf_rd_en;
        env_prev_addr = rf_rd_addr;
        if (op_en != 8'h00) begin
            env_en++;
            if (env_en - 1 == v.d) begin
                unit_done   = (8'b1 << v.op) | v.spur;
                unit_result = v.res;
            end else begin
                unit_done   = v.spur & ~(8'b1 << v.op);
                unit_result = 4'($urandom);
            end
        end else begin
            unit_done   = 8'h00;
            unit_result = 4'($urandom);
        end
    endtask

    task automatic run_cmd(input string tag, input vec_t v, input bit immediate,
                           input bit hold_next, input vec_t nv);
        int waited, t, first_rd, rd_addr, first_en, en_cnt, en_bad, opd_bad;
        int wr_cnt, wr_t, wr_addr, wr_data, first_resp, rcnt, unstable;
        int overlap, ready_bad, busy_bad, r_res, r_err;
        bit fin;
        rf_mem[v.rg] = v.init;
        env_en = 0; env_prev_rd = 1'b0;
        cmd_valid = 1'b1; cmd_opcode = v.op; cmd_reg = v.rg; cmd_pos = v.pos;
        waited = 0;
        while (!cmd_ready && waited < 40) begin
            @(negedge clk);
            env_step(v);
            waited++;
        end
        if (immediate) chk({tag, ".accept_wait"}, waited, 0);
        if (!cmd_ready) begin
            chk({tag, ".accepted"}, 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        first_rd = -1; rd_addr = -1; first_en = -1; en_cnt = 0; en_bad = 0; opd_bad = 0;
        wr_cnt = 0; wr_t = -1; wr_addr = -1; wr_data = -1; first_resp = -1; rcnt = 0;
        unstable = 0; overlap = 0; ready_bad = 0; busy_bad = 0; r_res = -1; r_err = -1;
        fin = 1'b0; t = 0;
        while (!fin && t < 60) begin
            @(negedge clk);
            t++;
            if (t == 1) begin
                if (hold_next) begin
                    cmd_opcode = nv.op; cmd_reg = nv.rg; cmd_pos = nv.pos;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (cmd_ready) ready_bad++;
            if (!busy) busy_bad++;
            if (rf_rd_en) begin
                if (first_rd < 0) first_rd = t;
                rd_addr = int'(rf_rd_addr);
            end
            if (op_en != 8'h00) begin
                en_cnt++;
                if (first_en < 0) first_en = t;
                if (op_en != v.exp_en) en_bad++;
            end
            if (t >= 3 && op_data != v.init) opd_bad++;
            if (int'(rf_rd_en) + int'(op_en != 8'h00) + int'(rf_wr_en) > 1) overlap++;
            if (rf_wr_en) begin
                wr_cnt++; wr_t = t; wr_addr = int'(rf_wr_addr); wr_data = int'(rf_wr_data);
            end
            resp_ready = 1'b0;
            if (resp_valid) begin
                rcnt++;
                if (first_resp < 0) begin
                    first_resp = t; r_res = int'(resp_result); r_err = int'(resp_err);
                end else if (int'(resp_result) != r_res || int'(resp_err) != r_err) begin
                    unstable++;
                end
                if (rcnt > v.bp) begin
                    resp_ready = 1'b1;
                    fin = 1'b1;
                end
            end
            env_step(v);
        end
        if (!fin) chk({tag, ".resp_seen"}, 0, 1);
        @(negedge clk);
        resp_ready = 1'b0;
        env_step(v);
        chk({tag, ".rd_cycle"}, first_rd, 1);
        chk({tag, ".rd_addr"}, rd_addr, int'(v.rg));
        chk({tag, ".en_first"}, first_en, 3);
        chk({tag, ".en_cycles"}, en_cnt, v.exp_en_cyc);
        chk({tag, ".en_value_bad"}, en_bad, 0);
        chk({tag, ".op_data_bad"}, opd_bad, 0);
        chk({tag, ".writes"}, wr_cnt, int'(v.exp_wr));
        if (v.exp_wr) begin
            chk({tag, ".wr_cycle"}, wr_t, v.exp_lat - 1);
            chk({tag, ".wr_addr"}, wr_addr, int'(v.rg));
            chk({tag, ".wr_data"}, wr_data, int'(v.exp_wdata));
            rf_mem[v.rg] = v.exp_wdata;
        end
        chk({tag, ".resp_cycle"}, first_resp, v.exp_lat);
        chk({tag, ".resp_result"}, r_res, int'(v.exp_result));
        chk({tag, ".resp_err"}, r_err, int'(v.exp_err));
        chk({tag, ".resp_cycles"}, rcnt, v.bp + 1);
        chk({tag, ".resp_unstable"}, unstable, 0);
        chk({tag, ".strobe_overlap"}, overlap, 0);
        chk({tag, ".cmd_ready_busy"}, ready_bad, 0);
        chk({tag, ".busy_low"}, busy_bad, 0);
        chk({tag, ".idle_after"}, int'({busy, resp_valid, cmd_ready}), 1);
    endtask

    // Abandon a command with rst, either in its first EXEC cycle or in WB.
    task automatic reset_mid(input string tag, input vec_t v, input bit at_wb);
        int t, waited, wr_after, resp_after, busy_after;
        bit hit;
        rf_mem[v.rg] = v.init;
        env_en = 0; env_prev_rd = 1'b0;
        cmd_valid = 1'b1; cmd_opcode = v.op; cmd_reg = v.rg; cmd_pos = v.pos;
        waited = 0;
        while (!cmd_ready && waited < 40) begin
            @(negedge clk);
            env_step(v);
            waited++;
        end
        hit = 1'b0; t = 0;
        while (!hit && t < 40) begin
            @(negedge clk);
            t++;
            if (t == 1) cmd_valid = 1'b0;
            if (at_wb ? rf_wr_en : (op_en != 8'h00)) hit = 1'b1;
            env_step(v);
        end
        cmd_valid = 1'b0;
        chk({tag, ".reached"}, int'(hit), 1);
        rst = 1'b1;
        @(negedge clk);
        chk({tag, ".op_en"}, int'(op_en), 0);
        chk({tag, ".busy"}, int'(busy), 0);
        chk({tag, ".wr_en"}, int'(rf_wr_en), 0);
        chk({tag, ".resp_valid"}, int'(resp_valid), 0);
        chk({tag, ".cmd_ready"}, int'(cmd_ready), 0);
        rst = 1'b0;
        unit_done = 8'h00;
        wr_after = 0; resp_after = 0; busy_after = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rf_wr_en) wr_after++;
            if (resp_valid) resp_after++;
            if (busy) busy_after++;
        end
        chk({tag, ".no_write"}, wr_after, 0);
        chk({tag, ".no_resp"}, resp_after, 0);
        chk({tag, ".stays_idle"}, busy_after, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench stalled");
    end

    initial begin
        vec_t v, v2, dummy;
        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_reg = '0; cmd_pos = 1'b0;
        rf_rd_data = '0; unit_done = '0; unit_result = '0; resp_ready = 1'b0;
        for (int i = 0; i < 8; i++) rf_mem[i] = 8'($urandom);

        //             op    rg    pos   init   d   res   spur   bp  en     cyc wr    wdata  res   err   lat
        tbl[0] = mkv(3'd0, 3'd3, 1'b0, 8'h25,  0, 4'h7, 8'h00, 0, 8'h01,  1, 1'b1, 8'h75, 4'h7, 1'b0,  5);
        tbl[1] = mkv(3'd4, 3'd1, 1'b1, 8'h9C,  1, 4'h1, 8'h01, 0, 8'h10,  2, 1'b0, 8'h91, 4'h1, 1'b0,  6);
        tbl[2] = mkv(3'd2, 3'd5, 1'b0, 8'h3A, -1, 4'h5, 8'h00, 0, 8'h04, 16, 1'b0, 8'h5A, 4'h0, 1'b1, 19);
        tbl[3] = mkv(3'd3, 3'd0, 1'b1, 8'hF0,  3, 4'hA, 8'h81, 1, 8'h08,  4, 1'b1, 8'hFA, 4'hA, 1'b0,  8);
        tbl[4] = mkv(3'd6, 3'd7, 1'b0, 8'h5B,  0, 4'hC, 8'h00, 2, 8'h40,  1, 1'b1, 8'hCB, 4'hC, 1'b0,  5);
        tbl[5] = mkv(3'd7, 3'd2, 1'b1, 8'h11, 15, 4'hE, 8'h00, 0, 8'h80, 16, 1'b1, 8'h1E, 4'hE, 1'b0, 20);
        tbl[6] = mkv(3'd5, 3'd4, 1'b0, 8'h6D,  2, 4'h3, 8'hDF, 0, 8'h20,  3, 1'b0, 8'h3D, 4'h3, 1'b0,  7);
        tbl[7] = mkv(3'd1, 3'd6, 1'b0, 8'h00,  0, 4'hF, 8'h00, 0, 8'h02,  1, 1'b1, 8'hF0, 4'hF, 1'b0,  5);

        // Reset held for three cycles: everything quiet, then ready.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("reset%0d.ctrl", k),
                int'({cmd_ready, rf_rd_en, op_en, rf_wr_en, resp_valid, resp_err, busy}), 0);
            chk($sformatf("reset%0d.data", k),
                int'({rf_rd_addr, op_data, rf_wr_addr, rf_wr_data, resp_result}), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("reset_release.cmd_ready", int'(cmd_ready), 1);
        chk("reset_release.busy", int'(busy), 0);
        chk("reset_release.strobes", int'({rf_rd_en, op_en, rf_wr_en, resp_valid}), 0);

        for (int i = 0; i < 8; i++) run_cmd($sformatf("vec%0d", i), tbl[i], 1'b0, 1'b0, tbl[i]);

        // Response backpressure with a second command waiting behind it.
        v  = mkv(3'd0, 3'd2, 1'b1, 8'h3C, 1, 4'h9, 8'h00, 3, 8'h01, 2, 1'b1, 8'h39, 4'h9, 1'b0, 6);
        v2 = mkv(3'd7, 3'd2, 1'b0, 8'h39, 0, 4'h4, 8'h00, 0, 8'h80, 1, 1'b1, 8'h49, 4'h4, 1'b0, 5);
        run_cmd("bp_first", v, 1'b0, 1'b1, v2);
        run_cmd("bp_second", v2, 1'b1, 1'b0, v2);

        // Reset during EXEC of complemento, then a normal command.
        dummy = model(3'd1, 3'd5, 1'b1, 8'hA6, -1, 4'h2, 8'h00, 0);
        reset_mid("rst_exec", dummy, 1'b0);
        v = mkv(3'd1, 3'd5, 1'b1, 8'hA6, 2, 4'h2, 8'h00, 0, 8'h02, 3, 1'b1, 8'hA2, 4'h2, 1'b0, 7);
        run_cmd("after_rst_exec", v, 1'b0, 1'b0, v);

        // Reset during WB.
        dummy = model(3'd0, 3'd3, 1'b0, 8'h44, 0, 4'h8, 8'h00, 0);
        reset_mid("rst_wb", dummy, 1'b1);

        // Random commands against the transaction-level expectation.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]    op;
            logic [AW-1:0] rg;
            logic          pos;
            int            dsel, d;
            op   = 3'($urandom_range(0, 7));
            rg   = AW'($urandom_range(0, 7));
            pos  = 1'($urandom);
            dsel = $urandom_range(0, 9);
            d    = (dsel == 9) ? -1 : ((dsel == 8) ? TO - 1 : int'($urandom_range(0, 4)));
            v = model(op, rg, pos, rf_mem[rg], d, 4'($urandom), 8'($urandom),
                      int'($urandom_range(0, 2)));
            run_cmd($sformatf("rnd%0d", i), v, 1'b0, 1'b0, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
